// File: rtl/incoming_ctx_sched_pkg.sv
//============================================================================
// Module : incoming_ctx_sched_pkg
// Purpose: Definitions shared by the per-flow context blocks: flow id width,
//          user context width and the scheduler state encoding.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

`ifndef USER_CONTEXT_W
`define USER_CONTEXT_W 64
`endif

package incoming_ctx_sched_pkg;

  localparam int FLOW_ID_W      = 10;
  localparam int USER_CONTEXT_W = `USER_CONTEXT_W;

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_PAUSED = 2'd3;

  typedef enum logic [1:0] {
    SCHED_INIT   = ST_INIT,
    SCHED_RUN    = ST_RUN,
    SCHED_DRAIN  = ST_DRAIN,
    SCHED_PAUSED = ST_PAUSED
  } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/incoming_ctx_sched_init_sweeper.sv
//============================================================================
// Module : ctx_init_sweeper
// Purpose: Zero-fill address generator run once after every reset. Walks the
//          pointer from 0 to all ones, one write per cycle, then stops.
// Ports  : clk, rst_n      clock, async active-low reset
//          wr_en           write strobe (active while sweeping)
//          addr            address being cleared this cycle
//          last            high in the cycle that clears the final address
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module ctx_init_sweeper #(
  parameter int PTR_W = incoming_ctx_sched_pkg::FLOW_ID_W
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             wr_en,
  output logic [PTR_W-1:0] addr,
  output logic             last
);

  logic             active;
  logic [PTR_W-1:0] ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b1;
      ptr    <= '0;
    end else if (active) begin
      ptr <= ptr + PTR_W'(1);
      if (ptr == '1) active <= 1'b0;
    end
  end

  // The sweep arms during reset; qualify with rst_n so the strobe stays low
  // while reset is held and the first write happens in the first free cycle.
  assign wr_en = active & rst_n;
  assign addr  = ptr;
  assign last  = active & (ptr == '1);

endmodule

`default_nettype wire

// File: rtl/incoming_ctx_sched.sv
//============================================================================
// Module : incoming_ctx_sched
// Purpose: Sequences incoming ACK events through the per-flow user logic:
//          read the flow context (RD), present it with the event for one
//          cycle and write the result back (EX). Zero-fills the context RAM
//          after reset and resolves back-to-back same-flow hazards.
// Config : INCOMING_CTX_FWD_EN  defined   -> hazards forwarded, no stall
//                               undefined -> one-cycle stall on a hazard
// Ports  : clk, rst_n                    clock, async active-low reset
//          ev_valid/ev_ready/ev_fid/ev_data  incoming event handshake
//          sched_en                      1 = accept, 0 = drain and pause
//          ctx_rd_en/addr/data           context RAM read (1-cycle latency)
//          ctx_wr_en/addr/data           context RAM write
//          udi_valid/fid/ev/cntxt_in     operands to the user logic (EX)
//          udi_cntxt_out                 user logic result (same cycle)
//          idle                          high while paused
//          ev_cnt, haz_cnt               saturating statistics
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module incoming_ctx_sched #(
  parameter int FLOW_ID_W = incoming_ctx_sched_pkg::FLOW_ID_W,
  parameter int CTX_W     = `USER_CONTEXT_W,
  parameter int EV_W      = 256,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ev_valid,
  output logic                 ev_ready,
  input  logic [FLOW_ID_W-1:0] ev_fid,
  input  logic [EV_W-1:0]      ev_data,
  input  logic                 sched_en,
  output logic                 ctx_rd_en,
  output logic [FLOW_ID_W-1:0] ctx_rd_addr,
  input  logic [CTX_W-1:0]     ctx_rd_data,
  output logic                 ctx_wr_en,
  output logic [FLOW_ID_W-1:0] ctx_wr_addr,
  output logic [CTX_W-1:0]     ctx_wr_data,
  output logic                 udi_valid,
  output logic [FLOW_ID_W-1:0] udi_fid,
  output logic [EV_W-1:0]      udi_ev,
  output logic [CTX_W-1:0]     udi_cntxt_in,
  input  logic [CTX_W-1:0]     udi_cntxt_out,
  output logic                 idle,
  output logic [CNT_W-1:0]     ev_cnt,
  output logic [CNT_W-1:0]     haz_cnt
);

  import incoming_ctx_sched_pkg::*;

  sched_state_e         state;
  logic                 ex_v;
  logic [FLOW_ID_W-1:0] ex_fid;
  logic [EV_W-1:0]      ex_ev;
  logic                 sweep_we;
  logic                 sweep_last;
  logic [FLOW_ID_W-1:0] sweep_addr;
  logic                 fid_match;
  logic                 haz;
  logic                 haz_stall;
  logic                 accept;
  logic [CTX_W-1:0]     ctx_sel;

  ctx_init_sweeper #(.PTR_W(FLOW_ID_W)) u_sweeper (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (sweep_we),
    .addr  (sweep_addr),
    .last  (sweep_last)
  );

  // The event registered last cycle is the one in EX now; a new event for
  // the same flow would read the RAM in the very cycle EX writes it back.
  assign fid_match = ex_v & (ev_fid == ex_fid);
  assign haz       = (state == SCHED_RUN) & sched_en & ev_valid & fid_match;

`ifdef INCOMING_CTX_FWD_EN
  logic             fwd_v;
  logic [CTX_W-1:0] fwd_q;

  assign haz_stall = 1'b0;

  // Capture the EX result for the colliding event; its RAM read is stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_v <= 1'b0;
      fwd_q <= '0;
    end else begin
      fwd_v <= accept & fid_match;
      if (accept & fid_match) fwd_q <= udi_cntxt_out;
    end
  end

  assign ctx_sel = fwd_v ? fwd_q : ctx_rd_data;
`else
  // Hold the second event back one cycle so its read sees the landed write.
  assign haz_stall = haz;
  assign ctx_sel   = ctx_rd_data;
`endif

  assign ev_ready    = (state == SCHED_RUN) & sched_en & ~haz_stall;
  assign accept      = ev_valid & ev_ready;
  assign ctx_rd_en   = accept;
  assign ctx_rd_addr = accept ? ev_fid : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v   <= 1'b0;
      ex_fid <= '0;
      ex_ev  <= '0;
    end else begin
      ex_v <= accept;
      if (accept) begin
        ex_fid <= ev_fid;
        ex_ev  <= ev_data;
      end
    end
  end

  assign udi_valid    = ex_v;
  assign udi_fid      = ex_fid;
  assign udi_ev       = ex_ev;
  assign udi_cntxt_in = ex_v ? ctx_sel : '0;

  // The sweep and EX never overlap: EX is empty throughout INIT.
  assign ctx_wr_en   = sweep_we | ex_v;
  assign ctx_wr_addr = sweep_we ? sweep_addr : (ex_v ? ex_fid : '0);
  assign ctx_wr_data = (ex_v & ~sweep_we) ? udi_cntxt_out : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_cnt  <= '0;
      haz_cnt <= '0;
    end else begin
      if (ex_v && ev_cnt != '1)  ev_cnt  <= ev_cnt + CNT_W'(1);
      if (haz && haz_cnt != '1)  haz_cnt <= haz_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SCHED_INIT;
      idle  <= 1'b0;
    end else begin
      case (state)
        SCHED_INIT: if (sweep_last) begin
          state <= sched_en ? SCHED_RUN : SCHED_PAUSED;
          idle  <= ~sched_en;
        end
        SCHED_RUN: if (!sched_en) state <= SCHED_DRAIN;
        // Nothing is accepted in DRAIN, so only EX can still be occupied.
        SCHED_DRAIN: if (!ex_v) begin
          state <= SCHED_PAUSED;
          idle  <= 1'b1;
        end
        SCHED_PAUSED: if (sched_en) begin
          state <= SCHED_RUN;
          idle  <= 1'b0;
        end
        default: begin
          state <= SCHED_INIT;
          idle  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_incoming_ctx_sched.sv
//============================================================================
// Module : tb_incoming_ctx_sched
// Purpose: Directed self-checking bench for incoming_ctx_sched with a 16-entry
//          read-first context RAM and a "+1" user logic.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_incoming_ctx_sched;

  localparam int FW = 4;
  localparam int CW = 16;
  localparam int EW = 256;
  localparam int NW = 4;

`ifdef INCOMING_CTX_FWD_EN
  localparam int EXP_STALLS = 0;
`else
  localparam int EXP_STALLS = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ev_valid;
  logic          ev_ready;
  logic [FW-1:0] ev_fid;
  logic [EW-1:0] ev_data;
  logic          sched_en;
  logic          ctx_rd_en;
  logic [FW-1:0] ctx_rd_addr;
  logic [CW-1:0] ctx_rd_data;
  logic          ctx_wr_en;
  logic [FW-1:0] ctx_wr_addr;
  logic [CW-1:0] ctx_wr_data;
  logic          udi_valid;
  logic [FW-1:0] udi_fid;
  logic [EW-1:0] udi_ev;
  logic [CW-1:0] udi_cntxt_in;
  logic [CW-1:0] udi_cntxt_out;
  logic          idle;
  logic [NW-1:0] ev_cnt;
  logic [NW-1:0] haz_cnt;

  logic          preload;
  logic [CW-1:0] mem [16];
  int            n_checks = 0;
  int            n_fail   = 0;

  always #5 clk = ~clk;

  incoming_ctx_sched #(.FLOW_ID_W(FW), .CTX_W(CW), .EV_W(EW), .CNT_W(NW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_fid        (ev_fid),
    .ev_data       (ev_data),
    .sched_en      (sched_en),
    .ctx_rd_en     (ctx_rd_en),
    .ctx_rd_addr   (ctx_rd_addr),
    .ctx_rd_data   (ctx_rd_data),
    .ctx_wr_en     (ctx_wr_en),
    .ctx_wr_addr   (ctx_wr_addr),
    .ctx_wr_data   (ctx_wr_data),
    .udi_valid     (udi_valid),
    .udi_fid       (udi_fid),
    .udi_ev        (udi_ev),
    .udi_cntxt_in  (udi_cntxt_in),
    .udi_cntxt_out (udi_cntxt_out),
    .idle          (idle),
    .ev_cnt        (ev_cnt),
    .haz_cnt       (haz_cnt)
  );

  // Read-first RAM: the read samples the old word when addresses collide.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'hA500 + 16'(i);
    end else begin
      if (ctx_rd_en) ctx_rd_data <= mem[ctx_rd_addr];
      if (ctx_wr_en) mem[ctx_wr_addr] <= ctx_wr_data;
    end
  end

  assign udi_cntxt_out = udi_cntxt_in + 16'd1;

  function automatic logic [EW-1:0] mk_ev(input logic [FW-1:0] f);
    return {8{28'h0C0DE00, f}};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; ev_valid = 1'b0; ev_fid = '0; ev_data = '0; sched_en = 1'b1; preload = 1'b1;
    @(posedge clk); #1 preload = 1'b0;
    @(negedge clk);
    n_checks++; if (ev_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_ready: got %0h want 0", ev_ready); end
    n_checks++; if (ctx_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %0h want 0", ctx_wr_en); end
    n_checks++; if (ctx_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %0h want 0", ctx_rd_en); end
    n_checks++; if (udi_valid !== 1'b0) begin n_fail++; $display("FAIL reset_udi_valid: got %0h want 0", udi_valid); end
    n_checks++; if (idle !== 1'b0)      begin n_fail++; $display("FAIL reset_idle: got %0h want 0", idle); end
    n_checks++; if (ev_cnt !== 4'd0 || haz_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", ev_cnt, haz_cnt); end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_checks++; if (ctx_wr_en !== 1'b1 || ctx_wr_addr !== 4'(i) || ctx_wr_data !== 16'h0)
        begin n_fail++; $display("FAIL init_write%0d: got en=%0h addr=%0d data=%0h want 1/%0d/0", i, ctx_wr_en, ctx_wr_addr, ctx_wr_data, i); end
      n_checks++; if (ev_ready !== 1'b0 || idle !== 1'b0)
        begin n_fail++; $display("FAIL init_ready%0d: got ready=%0h idle=%0h want 0/0", i, ev_ready, idle); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++; if (ev_ready !== 1'b1)  begin n_fail++; $display("FAIL init_done_ready: got %0h want 1", ev_ready); end
    n_checks++; if (ctx_wr_en !== 1'b0) begin n_fail++; $display("FAIL init_done_wr_en: got %0h want 0", ctx_wr_en); end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (mem[i] !== 16'h0) begin n_fail++; $display("FAIL init_zero%0d: got %0h want 0", i, mem[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    ev_valid = 1'b1; ev_fid = 4'd3; ev_data = mk_ev(4'd3);
    @(negedge clk);
    n_checks++; if (ev_ready !== 1'b1 || ctx_rd_en !== 1'b1 || ctx_rd_addr !== 4'd3 || ctx_wr_en !== 1'b0)
      begin n_fail++; $display("FAIL b2b_rd3: got rdy=%0h rd=%0h addr=%0d wr=%0h want 1/1/3/0", ev_ready, ctx_rd_en, ctx_rd_addr, ctx_wr_en); end
    @(posedge clk); #1 ev_fid = 4'd5; ev_data = mk_ev(4'd5);
    @(negedge clk);
    n_checks++; if (ctx_rd_addr !== 4'd5) begin n_fail++; $display("FAIL b2b_rd5: got %0d want 5", ctx_rd_addr); end
    n_checks++; if (udi_valid !== 1'b1 || udi_fid !== 4'd3 || udi_cntxt_in !== 16'd0)
      begin n_fail++; $display("FAIL b2b_ex3: got v=%0h fid=%0d in=%0h want 1/3/0", udi_valid, udi_fid, udi_cntxt_in); end
    n_checks++; if (udi_ev !== mk_ev(4'd3)) begin n_fail++; $display("FAIL b2b_ev3: got %0h want %0h", udi_ev, mk_ev(4'd3)); end
    n_checks++; if (ctx_wr_en !== 1'b1 || ctx_wr_addr !== 4'd3 || ctx_wr_data !== 16'd1)
      begin n_fail++; $display("FAIL b2b_wr3: got en=%0h addr=%0d data=%0h want 1/3/1", ctx_wr_en, ctx_wr_addr, ctx_wr_data); end
    @(posedge clk); #1 ev_fid = 4'd7; ev_data = mk_ev(4'd7);
    @(negedge clk);
    n_checks++; if (ctx_rd_addr !== 4'd7 || ctx_wr_addr !== 4'd5 || ctx_wr_en !== 1'b1)
      begin n_fail++; $display("FAIL b2b_rd7_wr5: got rd=%0d wr=%0d en=%0h want 7/5/1", ctx_rd_addr, ctx_wr_addr, ctx_wr_en); end
    @(posedge clk); #1 ev_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (ctx_rd_en !== 1'b0 || ctx_wr_en !== 1'b1 || ctx_wr_addr !== 4'd7)
      begin n_fail++; $display("FAIL b2b_wr7: got rd=%0h wr=%0h addr=%0d want 0/1/7", ctx_rd_en, ctx_wr_en, ctx_wr_addr); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (ctx_wr_en !== 1'b0) begin n_fail++; $display("FAIL b2b_wr_idle: got %0h want 0", ctx_wr_en); end
    n_checks++; if (ev_cnt !== 4'd3 || haz_cnt !== 4'd0) begin n_fail++; $display("FAIL b2b_counters: got %0d/%0d want 3/0", ev_cnt, haz_cnt); end
    n_checks++; if (mem[3] !== 16'd1 || mem[5] !== 16'd1 || mem[7] !== 16'd1)
      begin n_fail++; $display("FAIL b2b_mem: got %0h/%0h/%0h want 1/1/1", mem[3], mem[5], mem[7]); end
    @(posedge clk); #1;
  endtask

  task automatic test_hazard();
    int stalls;
    bit acc;
    stalls = 0; acc = 1'b0;
    ev_valid = 1'b1; ev_fid = 4'd9; ev_data = mk_ev(4'd9);
    @(negedge clk);
    n_checks++; if (ev_ready !== 1'b1) begin n_fail++; $display("FAIL haz_first_ready: got %0h want 1", ev_ready); end
    @(posedge clk); #1;
    for (int i = 0; i < 6 && !acc; i++) begin
      @(negedge clk);
      if (ev_ready) acc = 1'b1; else stalls++;
      @(posedge clk); #1;
    end
    ev_valid = 1'b0;
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL haz_accept_timeout: got %0d want 1", acc); end
    n_checks++; if (stalls !== EXP_STALLS) begin n_fail++; $display("FAIL haz_stalls: got %0d want %0d", stalls, EXP_STALLS); end
    @(negedge clk);
    n_checks++; if (udi_valid !== 1'b1 || udi_fid !== 4'd9 || udi_cntxt_in !== 16'd1 || ctx_wr_data !== 16'd2)
      begin n_fail++; $display("FAIL haz_ex2: got v=%0h fid=%0d in=%0h wr=%0h want 1/9/1/2", udi_valid, udi_fid, udi_cntxt_in, ctx_wr_data); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (mem[9] !== 16'd2) begin n_fail++; $display("FAIL haz_ctx9: got %0h want 2", mem[9]); end
    n_checks++; if (haz_cnt !== 4'd1 || ev_cnt !== 4'd5) begin n_fail++; $display("FAIL haz_counters: got %0d/%0d want 1/5", haz_cnt, ev_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_drain();
    ev_valid = 1'b1; ev_fid = 4'd1; ev_data = mk_ev(4'd1);
    @(posedge clk); #1 ev_fid = 4'd2; ev_data = mk_ev(4'd2);
    @(posedge clk); #1 sched_en = 1'b0; ev_fid = 4'd6; ev_data = mk_ev(4'd6);
    @(negedge clk);
    n_checks++; if (ev_ready !== 1'b0 || ctx_rd_en !== 1'b0) begin n_fail++; $display("FAIL drain_ready: got %0h/%0h want 0/0", ev_ready, ctx_rd_en); end
    n_checks++; if (ctx_wr_en !== 1'b1 || ctx_wr_addr !== 4'd2 || idle !== 1'b0)
      begin n_fail++; $display("FAIL drain_wr2: got en=%0h addr=%0d idle=%0h want 1/2/0", ctx_wr_en, ctx_wr_addr, idle); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (udi_valid !== 1'b0 || idle !== 1'b0 || ev_ready !== 1'b0)
      begin n_fail++; $display("FAIL drain_state: got v=%0h idle=%0h rdy=%0h want 0/0/0", udi_valid, idle, ev_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL drain_idle: got %0h want 1", idle); end
    n_checks++; if (mem[1] !== 16'd1 || mem[2] !== 16'd1 || mem[6] !== 16'd0)
      begin n_fail++; $display("FAIL drain_mem: got %0h/%0h/%0h want 1/1/0", mem[1], mem[2], mem[6]); end
    n_checks++; if (ev_cnt !== 4'd7) begin n_fail++; $display("FAIL drain_ev_cnt: got %0d want 7", ev_cnt); end
    @(posedge clk); #1 ev_valid = 1'b0; sched_en = 1'b1;
    @(negedge clk);
    n_checks++; if (idle !== 1'b1 || ev_ready !== 1'b0) begin n_fail++; $display("FAIL resume_wait: got idle=%0h rdy=%0h want 1/0", idle, ev_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (idle !== 1'b0 || ev_ready !== 1'b1) begin n_fail++; $display("FAIL resume_run: got idle=%0h rdy=%0h want 0/1", idle, ev_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    logic [FW-1:0] fids [10];
    fids = '{4'd4, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2};
    for (int i = 0; i < 7; i++) begin
      ev_valid = 1'b1; ev_fid = fids[i]; ev_data = mk_ev(fids[i]);
      @(posedge clk); #1;
    end
    ev_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (ev_cnt !== 4'd14) begin n_fail++; $display("FAIL sat_pre: got %0d want 14", ev_cnt); end
    n_checks++; if (mem[4] !== 16'd1) begin n_fail++; $display("FAIL sat_ctx4: got %0h want 1", mem[4]); end
    @(posedge clk); #1;
    for (int i = 7; i < 10; i++) begin
      ev_valid = 1'b1; ev_fid = fids[i]; ev_data = mk_ev(fids[i]);
      @(posedge clk); #1;
    end
    ev_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (ev_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d want 15", ev_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    ev_valid = 1'b1; ev_fid = 4'd4; ev_data = mk_ev(4'd4);
    @(posedge clk); #1 ev_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (udi_valid !== 1'b1 || udi_fid !== 4'd4 || udi_cntxt_in !== 16'd1)
      begin n_fail++; $display("FAIL mrst_ex4: got v=%0h fid=%0d in=%0h want 1/4/1", udi_valid, udi_fid, udi_cntxt_in); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (ctx_wr_en !== 1'b0 || udi_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_kill: got wr=%0h v=%0h want 0/0", ctx_wr_en, udi_valid); end
    n_checks++; if (ev_cnt !== 4'd0) begin n_fail++; $display("FAIL mrst_ev_cnt: got %0d want 0", ev_cnt); end
    @(posedge clk); #1;
    n_checks++; if (mem[4] !== 16'd1) begin n_fail++; $display("FAIL mrst_no_write: got %0h want 1", mem[4]); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (ctx_wr_en !== 1'b1 || ctx_wr_addr !== 4'd0)
      begin n_fail++; $display("FAIL mrst_init_restart: got en=%0h addr=%0d want 1/0", ctx_wr_en, ctx_wr_addr); end
    repeat (16) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++; if (mem[4] !== 16'd0) begin n_fail++; $display("FAIL mrst_ctx4: got %0h want 0", mem[4]); end
    n_checks++; if (ev_ready !== 1'b1 || idle !== 1'b0) begin n_fail++; $display("FAIL mrst_run: got rdy=%0h idle=%0h want 1/0", ev_ready, idle); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_hazard();
    test_drain();
    test_saturation();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

`default_nettype wire
